// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the 2x2 MAC tile datapath:
//   seq_state_t    - sequencer FSM state encoding
//   DEF_*          - default operand / accumulator widths and reduction length
//   min_acc_width  - smallest accumulator width that cannot overflow for a
//                    full-length unsigned reduction
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_OUTPUT  = 3'd5
    } seq_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int DEF_MAX_K      = 16;

    // Each product needs 2*data_width bits; summing max_k of them adds
    // clog2(max_k) bits of growth.
    function automatic int min_acc_width(input int data_width, input int max_k);
        return (2 * data_width) + $clog2(max_k);
    endfunction

endpackage

// File: rtl/mac_array_2x2.sv
// -----------------------------------------------------------------------------
// mac_array_2x2
// Four independent unsigned multiply-accumulate lanes. Lane n multiplies
// a[n] by b[n] and adds the product to acc[n] on every enabled clock.
// clear_all zeroes all four accumulators and takes priority over enable.
// Ports:
//   clock      in   clock, all logic on posedge
//   reset      in   synchronous active-high reset, zeroes accumulators
//   enable     in   accumulate this cycle
//   clear_all  in   zero all accumulators this cycle
//   a, b       in   4 packed operands per side, lane 0 in the LSBs
//   acc        out  4 packed accumulators, lane 0 in the LSBs
// Accumulators wrap modulo 2^ACC_WIDTH.
// -----------------------------------------------------------------------------
module mac_array_2x2
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_all,
    input  logic [4*DATA_WIDTH-1:0] a,
    input  logic [4*DATA_WIDTH-1:0] b,
    output logic [4*ACC_WIDTH-1:0]  acc
);

    logic [ACC_WIDTH-1:0] acc_r [4];

    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [2*DATA_WIDTH-1:0] prod_s;

        // Full-width unsigned product of this lane's operands.
        always_comb begin
            prod_s = {{DATA_WIDTH{1'b0}}, a[n*DATA_WIDTH +: DATA_WIDTH]}
                   * {{DATA_WIDTH{1'b0}}, b[n*DATA_WIDTH +: DATA_WIDTH]};
        end

        // Accumulator register: clear wins over enable.
        always_ff @(posedge clock) begin
            if (reset) begin
                acc_r[n] <= {ACC_WIDTH{1'b0}};
            end else if (clear_all) begin
                acc_r[n] <= {ACC_WIDTH{1'b0}};
            end else if (enable) begin
                acc_r[n] <= acc_r[n] + ACC_WIDTH'(prod_s);
            end else begin
                acc_r[n] <= acc_r[n];
            end
        end
    end

    // Pack lane accumulators onto the output bus.
    always_comb begin
        acc = {4*ACC_WIDTH{1'b0}};
        for (int n = 0; n < 4; n++) begin
            acc[n*ACC_WIDTH +: ACC_WIDTH] = acc_r[n];
        end
    end

endmodule

// File: rtl/mac_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// mac_matmul_sequencer
// Drives a mac_array_2x2 to compute one 2x2 tile C = A(2xK) x B(Kx2) per job.
// A job is: accept start (latch K, clamped to MAX_K), pulse mac_clear once,
// stream K operand beats into the array, wait for the last accumulate to
// land, snapshot the accumulators and hold them on the result port until
// downstream takes them.
// Ports:
//   clock, reset           clock and synchronous active-high reset
//   start, k_len           job request (IDLE only) and its reduction length
//   busy                   high whenever not IDLE
//   in_valid/in_ready      operand beat handshake
//   in_a0,in_a1,in_b0,in_b1  A[0][k], A[1][k], B[k][0], B[k][1]
//   mac_enable, mac_clear  array control
//   mac_a, mac_b           per-lane operands {x_11,x_10,x_01,x_00}
//   mac_acc                array accumulators {acc_11,acc_10,acc_01,acc_00}
//   res_valid/res_ready    result handshake
//   res_data               result tile {C11,C10,C01,C00}
// All outputs are registered.
// -----------------------------------------------------------------------------
module mac_matmul_sequencer
    import mac_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int  MAX_K      = DEF_MAX_K,
    localparam int K_W        = $clog2(MAX_K + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a0,
    input  logic [DATA_WIDTH-1:0]   in_a1,
    input  logic [DATA_WIDTH-1:0]   in_b0,
    input  logic [DATA_WIDTH-1:0]   in_b1,
    output logic                    mac_enable,
    output logic                    mac_clear,
    output logic [4*DATA_WIDTH-1:0] mac_a,
    output logic [4*DATA_WIDTH-1:0] mac_b,
    input  logic [4*ACC_WIDTH-1:0]  mac_acc,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*ACC_WIDTH-1:0]  res_data
);

    localparam logic [K_W-1:0] MAX_K_L = K_W'(MAX_K);

    seq_state_t     state_r;
    logic [K_W-1:0] cnt_r;
    logic [K_W-1:0] klen_r;
    logic [K_W-1:0] k_clamped_s;
    logic [K_W-1:0] cnt_inc_s;
    logic           in_hs_s;

    // Requested length clamped to MAX_K, and the beat handshake/next count.
    always_comb begin
        if (k_len > MAX_K_L) begin
            k_clamped_s = MAX_K_L;
        end else begin
            k_clamped_s = k_len;
        end
        cnt_inc_s = cnt_r + K_W'(1'b1);
        in_hs_s   = in_valid & in_ready;
    end

    // Job FSM with beat counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {K_W{1'b0}};
            klen_r     <= {K_W{1'b0}};
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            mac_enable <= 1'b0;
            mac_clear  <= 1'b0;
            mac_a      <= {4*DATA_WIDTH{1'b0}};
            mac_b      <= {4*DATA_WIDTH{1'b0}};
            res_valid  <= 1'b0;
            res_data   <= {4*ACC_WIDTH{1'b0}};
        end else begin
            // Array controls are single-cycle pulses unless re-asserted below.
            mac_clear  <= 1'b0;
            mac_enable <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        klen_r    <= k_clamped_s;
                        cnt_r     <= {K_W{1'b0}};
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                        state_r   <= ST_CLEAR;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end

                ST_CLEAR: begin
                    // A zero-length job skips straight to the snapshot of
                    // the freshly cleared accumulators.
                    if (klen_r != {K_W{1'b0}}) begin
                        in_ready <= 1'b1;
                        state_r  <= ST_STREAM;
                    end else begin
                        state_r  <= ST_CAPTURE;
                    end
                end

                ST_STREAM: begin
                    // Enable travels with the registered operands so the
                    // array sees each beat exactly once.
                    mac_enable <= in_hs_s;
                    if (in_hs_s) begin
                        mac_a <= {in_a1, in_a1, in_a0, in_a0};
                        mac_b <= {in_b1, in_b0, in_b1, in_b0};
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == klen_r) begin
                            in_ready <= 1'b0;
                            state_r  <= ST_DRAIN;
                        end else begin
                            state_r  <= ST_STREAM;
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end

                ST_DRAIN: begin
                    // Last enable is on the array this cycle.
                    state_r <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    res_data  <= mac_acc;
                    res_valid <= 1'b1;
                    state_r   <= ST_OUTPUT;
                end

                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cnt_r     <= {K_W{1'b0}};
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_OUTPUT;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= {K_W{1'b0}};
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_matmul_sequencer
// Sequencer plus mac_array_2x2 driven through directed jobs. Expected tiles
// are pushed to a scoreboard queue when a job is launched and popped when the
// result port presents a tile. A negedge monitor tallies array pulses and
// handshakes for the timing/invariant checks.
// -----------------------------------------------------------------------------
module tb_mac_matmul_sequencer;
    import mac_pkg::*;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int MK = 16;
    localparam int KW = $clog2(MK + 1);

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a0, in_a1, in_b0, in_b1;
    logic            mac_enable;
    logic            mac_clear;
    logic [4*DW-1:0] mac_a;
    logic [4*DW-1:0] mac_b;
    logic [4*AW-1:0] mac_acc;
    logic            res_valid;
    logic            res_ready;
    logic [4*AW-1:0] res_data;

    always #5 clock = ~clock;

    mac_matmul_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MK)) u_seq (
        .clock(clock), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
        .mac_enable(mac_enable), .mac_clear(mac_clear),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    mac_array_2x2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_arr (
        .clock(clock), .reset(reset), .enable(mac_enable), .clear_all(mac_clear),
        .a(mac_a), .b(mac_b), .acc(mac_acc)
    );

    int checks = 0;
    int errors = 0;
    logic [4*AW-1:0] sb [$];

    // Monitor state.
    int cyc = 0;
    int en_count = 0, clr_count = 0, rdy_count = 0, hs_count = 0;
    int overlap = 0, rdy_viol = 0, stab_viol = 0;
    int last_hs_cyc = 0, start_cyc = 0, clr_cyc = 0, first_en_cyc = -1;
    logic            prev_hold = 1'b0;
    logic [4*AW-1:0] prev_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mac_enable) en_count <= en_count + 1;
        if (mac_enable && first_en_cyc < 0) first_en_cyc <= cyc;
        if (mac_clear) begin
            clr_count    <= clr_count + 1;
            clr_cyc      <= cyc;
            first_en_cyc <= -1;
        end
        if (mac_enable && mac_clear) overlap <= overlap + 1;
        if (in_ready) rdy_count <= rdy_count + 1;
        if (in_ready && (!busy || res_valid || mac_clear)) rdy_viol <= rdy_viol + 1;
        if (in_valid && in_ready) begin
            hs_count    <= hs_count + 1;
            last_hs_cyc <= cyc;
        end
        if (start && !busy && !reset) start_cyc <= cyc;
        if (prev_hold && (res_data !== prev_data)) stab_viol <= stab_viol + 1;
        prev_hold <= res_valid && !res_ready;
        prev_data <= res_data;
    end

    task automatic chk(input string tag, input logic [4*AW-1:0] obs, input logic [4*AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        k_len = '0;
    endtask

    task automatic send_beat(input logic [DW-1:0] a0, a1, b0, b1, input int gap);
        bit done = 1'b0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge clock);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("beat_accepted", done, 1'b1);
    endtask

    task automatic get_result(input string tag, input int delay, output int rv_cyc);
        bit seen = 1'b0;
        logic [4*AW-1:0] exp_t;
        for (int w = 0; w < 60 && !seen; w++) begin
            @(negedge clock);
            if (res_valid) seen = 1'b1;
        end
        rv_cyc = cyc;
        chk({tag, "_res_valid_seen"}, seen, 1'b1);
        if (seen) begin
            if (sb.size() > 0) exp_t = sb.pop_front();
            else exp_t = 'x;
            chk({tag, "_res_data"}, res_data, exp_t);
            repeat (delay) @(negedge clock);
            res_ready = 1'b1;
            @(posedge clock);
            #1;
            res_ready = 1'b0;
            chk({tag, "_res_valid_drop"}, {busy, res_valid}, 2'b00);
        end
    endtask

    // Test-1 tile: C00=19, C01=22, C10=43, C11=50.
    localparam logic [4*AW-1:0] TILE1 = {20'd50, 20'd43, 20'd22, 20'd19};

    initial begin
        int rv, e0, c0, r0, h0;
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0; res_ready = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", {busy, in_ready, res_valid, mac_enable, mac_clear}, 5'b0);
        chk("reset_mac_ab", {mac_a, mac_b}, '0);
        chk("reset_res_data", res_data, '0);
        reset = 1'b0;
        tick();

        // 1: basic K=2 job.
        sb.push_back(TILE1);
        e0 = en_count; c0 = clr_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 0);
        get_result("t1", 0, rv);
        chk("t1_latency", rv - last_hs_cyc, 3);
        chk("t1_enable_cycles", en_count - e0, 2);
        chk("t1_clear_pulses", clr_count - c0, 1);
        chk("t1_clear_before_enable", first_en_cyc > clr_cyc, 1'b1);

        // 2: input gaps and result back-pressure.
        sb.push_back(TILE1);
        e0 = en_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 2);
        get_result("t2", 5, rv);
        chk("t2_enable_cycles", en_count - e0, 2);
        chk("t2_res_stable", stab_viol, 0);

        // 3: zero-length job.
        sb.push_back('0);
        e0 = en_count; c0 = clr_count; r0 = rdy_count;
        start_job(0);
        get_result("t3", 0, rv);
        chk("t3_latency", rv - start_cyc, 3);
        chk("t3_in_ready_never", rdy_count - r0, 0);
        chk("t3_clear_pulses", clr_count - c0, 1);
        chk("t3_no_enable", en_count - e0, 0);

        // 4: full-length worst case, requested K=20 clamps to 16.
        sb.push_back({4{20'd1040400}});
        e0 = en_count; h0 = hs_count;
        start_job(20);
        for (int i = 0; i < 16; i++) send_beat(8'd255, 8'd255, 8'd255, 8'd255, 0);
        chk("t4_in_ready_after_last", in_ready, 1'b0);
        get_result("t4", 0, rv);
        chk("t4_beats", hs_count - h0, 16);
        chk("t4_enable_cycles", en_count - e0, 16);

        // 5: back-to-back jobs, stray start mid-job ignored.
        sb.push_back(TILE1);
        c0 = clr_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        start = 1'b1; k_len = KW'(1);
        tick();
        start = 1'b0; k_len = '0;
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 0);
        get_result("t5a", 0, rv);
        chk("t5a_clear_pulses", clr_count - c0, 1);
        sb.push_back({4{20'd1}});
        start_job(1);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 0);
        get_result("t5b", 0, rv);
        chk("t5_clear_pulses", clr_count - c0, 2);
        chk("t5b_clear_before_enable", first_en_cyc > clr_cyc, 1'b1);

        // 6: reset mid-stream discards the tile, next job is clean.
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_after_reset", {busy, in_ready, res_valid, mac_enable, mac_clear}, 5'b0);
        chk("t6_mac_a_reset", mac_a, '0);
        tick();
        sb.push_back(TILE1);
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 0);
        get_result("t6", 0, rv);

        repeat (2) tick();
        chk("clear_enable_overlap", overlap, 0);
        chk("in_ready_outside_stream", rdy_viol, 0);
        chk("res_data_stable", stab_viol, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_matmul_sequencer.md
Name: mac_matmul_sequencer

Overview:
Upstream controller for mac_array_2x2. It computes one 2x2 output tile, C = A(2xK) x B(Kx2), per job.
- Accepts K operand beats over a valid/ready stream and broadcasts them to the four MACs.
- Drives the array's enable and clear_all.
- Snapshots the four accumulators and presents the tile downstream on a valid/ready result port.

Parameters:
DATA_WIDTH, 8, operand width; matches mac_array_2x2.
ACC_WIDTH, 20, accumulator width; matches mac_array_2x2.
MAX_K, 16, maximum reduction length. Derived localparam K_W = $clog2(MAX_K+1).

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  job request; sampled only in IDLE
k_len  in  K_W  reduction length for the job; latched on accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
in_a0  in  DATA_WIDTH  A[0][k]
in_a1  in  DATA_WIDTH  A[1][k]
in_b0  in  DATA_WIDTH  B[k][0]
in_b1  in  DATA_WIDTH  B[k][1]
mac_enable  out  1  to array enable
mac_clear  out  1  to array clear_all
mac_a  out  4*DATA_WIDTH  {a_11,a_10,a_01,a_00}
mac_b  out  4*DATA_WIDTH  {b_11,b_10,b_01,b_00}
mac_acc  in  4*ACC_WIDTH  {acc_11,acc_10,acc_01,acc_00} from array
res_valid  out  1  result tile valid
res_ready  in  1  downstream accepts tile
res_data  out  4*ACC_WIDTH  {C11,C10,C01,C00}

Behaviour:
- Reset: sync; state = IDLE. Every output is 0, including mac_a, mac_b, res_data and mac_clear. The beat counter is 0. The array is cleared by its own reset, not by this block.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CAPTURE, OUTPUT.
- IDLE: in_ready=0. On start=1, latch klen_q = min(k_len, MAX_K) and go to CLEAR. start in any other state is ignored.
- CLEAR: mac_clear=1 for exactly 1 cycle. Next state is STREAM if klen_q>0, else CAPTURE.
- STREAM:
  - in_ready=1 while cnt < klen_q.
  - On each handshake, register operands: mac_a <= {in_a1,in_a1,in_a0,in_a0}; mac_b <= {in_b1,in_b0,in_b1,in_b0}.
  - mac_enable is registered and equals the previous cycle's handshake. It is high for exactly one cycle per beat, aligned with that beat's operands.
  - cnt increments per handshake. On the handshake where cnt+1 == klen_q, go to DRAIN, and in_ready is 0 from the next cycle.
  - Input gaps (in_valid=0) give mac_enable=0; mac_a and mac_b hold their last value.
- DRAIN: 1 cycle. This is the cycle in which the last mac_enable is high. Then go to CAPTURE.
- CAPTURE: res_data <= mac_acc. Then go to OUTPUT.
- OUTPUT:
  - res_valid=1; res_data held stable until res_ready.
  - On the handshake, go to IDLE and clear cnt.
- Latency:
  - Last input handshake at cycle t gives res_valid at t+3.
  - For k_len=0, start accepted at cycle s gives res_valid at s+3.
- Invariant: mac_clear and mac_enable are never high in the same cycle.
- Width rule: ACC_WIDTH >= 2*DATA_WIDTH + $clog2(MAX_K) guarantees no overflow; with the defaults, 20 >= 16+4. Below that, the array wraps modulo 2^ACC_WIDTH and this block does not flag it.
- Unsigned operands only.
- Reset mid-job: immediate return to IDLE. Outputs follow the reset values above, and a partial tile is discarded. The next job's CLEAR state guarantees clean accumulators.
- Back-to-back jobs: start may be asserted in the cycle after the OUTPUT handshake.

Decomposition:
- Package mac_pkg holds:
  - typedef enum logic [2:0] seq_state_t (the six states);
  - default DATA_WIDTH/ACC_WIDTH/MAX_K constants;
  - a function computing the minimum ACC_WIDTH.
- No sub-module: the counter and FSM stay inline.
- The bench wraps this block plus mac_array_2x2 as the DUT.

Test Plan:
1. K=2, beats (a0,a1,b0,b1) = (1,3,5,6) then (2,4,7,8) -> res_data C00=19, C01=22, C10=43, C11=50; mac_enable high exactly 2 cycles; res_valid 3 cycles after the last beat.
2. Same job with in_valid gaps (1-0-0-1) and res_ready low for 5 cycles -> identical result; res_data stable while res_valid && !res_ready; in_ready=0 outside STREAM.
3. k_len=0 -> in_ready never high; one mac_clear pulse; res_data all zero at s+3.
4. k_len=16, all operands 255 -> each Cij=1040400 with no wrap; k_len=20 is clamped to 16 beats.
5. Two back-to-back jobs (test 1, then K=1 with (1,1,1,1)), second start asserted mid-job ignored -> second tile is all 1s; mac_clear precedes the first enable of each job.
6. reset asserted for one cycle in STREAM after 1 beat -> next cycle busy=0, in_ready=0, res_valid=0, mac_enable=0; a following test 1 job gives 19/22/43/50.
